// File: rtl/display_arbiter_if.sv
// rtl/display_arbiter_if.sv - requester and 7-segment digit signals of the display arbiter
interface display_arbiter_if;
  logic        req_a;
  logic [15:0] datos_a;
  logic        req_b;
  logic [15:0] datos_b;
  logic [3:0]  unidades;
  logic [3:0]  decenas;
  logic [3:0]  centenas;
  logic [3:0]  unidadesMillar;
  logic        grant_a;
  logic        grant_b;
  logic        cambio;

  modport master (
    output req_a, datos_a, req_b, datos_b,
    input  unidades, decenas, centenas, unidadesMillar, grant_a, grant_b, cambio
  );

  modport slave (
    input  req_a, datos_a, req_b, datos_b,
    output unidades, decenas, centenas, unidadesMillar, grant_a, grant_b, cambio
  );
endinterface

// File: rtl/display_arbiter.sv
// rtl/display_arbiter.sv - two-requester display arbiter with minimum hold time and round-robin handoff
module display_arbiter #(
  parameter int         HOLD_CYCLES = 50000000,
  parameter logic [3:0] IDLE_DIGIT  = 4'h0
) (
  input  logic              clk,
  input  logic              rst_n,
  display_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SHOW_A, SHOW_B} state_t;

  localparam logic [25:0] HOLD_LAST = 26'(HOLD_CYCLES - 1);

  state_t      state_q, state_d;
  logic [25:0] cnt_q, cnt_d;
  logic [15:0] digits_q, digits_d;
  logic        cambio_q, cambio_d;
  logic        run_q;
  logic        hold_done;

  // run_q keeps the FSM in IDLE for the first edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q    <= 1'b0;
      state_q  <= IDLE;
      cnt_q    <= '0;
      digits_q <= {4{IDLE_DIGIT}};
      cambio_q <= 1'b0;
    end else begin
      run_q    <= 1'b1;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      digits_q <= digits_d;
      cambio_q <= cambio_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    hold_done = (cnt_q == HOLD_LAST);
    if (run_q) begin
      case (state_q)
        IDLE: begin
          if (bus.req_a)      state_d = SHOW_A;
          else if (bus.req_b) state_d = SHOW_B;
        end
        SHOW_A: begin
          if (hold_done) begin
            if (bus.req_b)      state_d = SHOW_B;
            else if (bus.req_a) state_d = SHOW_A;
            else                state_d = IDLE;
          end
        end
        SHOW_B: begin
          if (hold_done) begin
            if (bus.req_a)      state_d = SHOW_A;
            else if (bus.req_b) state_d = SHOW_B;
            else                state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q)
      cnt_d = '0;
    else if (state_q != IDLE && !hold_done)
      cnt_d = cnt_q + 26'd1;
  end

  // A non-requesting owner keeps its last digits frozen
  always_comb begin
    digits_d = digits_q;
    if (state_d == SHOW_A && bus.req_a)
      digits_d = bus.datos_a;
    else if (state_d == SHOW_B && bus.req_b)
      digits_d = bus.datos_b;
    else if (state_d == IDLE)
      digits_d = {4{IDLE_DIGIT}};
  end

  assign cambio_d = (state_d != state_q) && (state_d != IDLE);

  assign bus.unidades       = digits_q[3:0];
  assign bus.decenas        = digits_q[7:4];
  assign bus.centenas       = digits_q[11:8];
  assign bus.unidadesMillar = digits_q[15:12];
  assign bus.grant_a        = (state_q == SHOW_A);
  assign bus.grant_b        = (state_q == SHOW_B);
  assign bus.cambio         = cambio_q;

endmodule

// File: tb/tb_display_arbiter.sv
// tb/tb_display_arbiter.sv - directed self-checking bench for display_arbiter
module tb_display_arbiter;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_assert = 0;
  int   n_fail   = 0;

  display_arbiter_if bus ();

  display_arbiter #(
    .HOLD_CYCLES (4),
    .IDLE_DIGIT  (4'h0)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  logic [15:0] digits;
  logic [2:0]  gbc;
  assign digits = {bus.unidadesMillar, bus.centenas, bus.decenas, bus.unidades};
  assign gbc    = {bus.grant_a, bus.grant_b, bus.cambio};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // exp_g is {grant_a, grant_b, cambio}
  task automatic chk(input string tag, input logic [2:0] exp_g, input logic [15:0] exp_d);
    n_assert++;
    assert (gbc === exp_g) else begin
      n_fail++;
      $error("FAIL %s grant/cambio: observed %b expected %b", tag, gbc, exp_g);
    end
    n_assert++;
    assert (digits === exp_d) else begin
      n_fail++;
      $error("FAIL %s digits: observed %h expected %h", tag, digits, exp_d);
    end
  endtask

  initial begin
    bus.req_a   = 1'b0;
    bus.req_b   = 1'b0;
    bus.datos_a = 16'h0000;
    bus.datos_b = 16'h0000;
    rst_n       = 1'b0;
    tick();
    tick();
    chk("reset", 3'b000, 16'h0000);

    rst_n       = 1'b1;
    bus.req_a   = 1'b1;
    bus.datos_a = 16'h1234;
    tick();
    chk("release_edge1", 3'b000, 16'h0000);
    tick();
    chk("grant_a_first", 3'b101, 16'h1234);
    tick();
    chk("cambio_drop", 3'b100, 16'h1234);

    bus.datos_a = 16'h5678;
    bus.req_b   = 1'b1;
    bus.datos_b = 16'hBEEF;
    tick();
    chk("track_a_1", 3'b100, 16'h5678);
    bus.datos_a = 16'hABCD;
    bus.datos_b = 16'hF00D;
    tick();
    chk("no_preempt", 3'b100, 16'hABCD);
    bus.datos_b = 16'hBEEF;
    tick();
    chk("switch_to_b", 3'b011, 16'hBEEF);
    tick();
    chk("b_hold1", 3'b010, 16'hBEEF);
    bus.datos_a = 16'h2222;
    tick();
    chk("nonowner_a", 3'b010, 16'hBEEF);
    bus.datos_b = 16'h1357;
    tick();
    chk("track_b", 3'b010, 16'h1357);
    tick();
    chk("switch_to_a", 3'b101, 16'h2222);

    bus.req_b   = 1'b0;
    bus.datos_a = 16'h1234;
    tick();
    chk("a_load", 3'b100, 16'h1234);
    bus.req_a   = 1'b0;
    bus.datos_a = 16'h9999;
    tick();
    chk("freeze1", 3'b100, 16'h1234);
    tick();
    chk("freeze2", 3'b100, 16'h1234);
    tick();
    chk("to_idle", 3'b000, 16'h0000);

    bus.req_b   = 1'b1;
    bus.datos_b = 16'h4321;
    tick();
    chk("idle_to_b", 3'b011, 16'h4321);
    tick();
    chk("b_hold_pre_rst", 3'b010, 16'h4321);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_reset", 3'b000, 16'h0000);
    tick();
    rst_n = 1'b1;
    tick();
    chk("rst_release_edge1", 3'b000, 16'h0000);
    tick();
    chk("regrant_b", 3'b011, 16'h4321);
    bus.req_a   = 1'b1;
    bus.datos_a = 16'h0F0F;
    tick();
    chk("fresh_hold1", 3'b010, 16'h4321);
    tick();
    chk("fresh_hold2", 3'b010, 16'h4321);
    tick();
    chk("fresh_hold3", 3'b010, 16'h4321);
    tick();
    chk("handoff_a", 3'b101, 16'h0F0F);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
